// File: rtl/serial_to_parallel32_pkg.sv
// Shared constants for the serial_to_parallel32 deserializer slice.
package serial_to_parallel32_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  // Counter width for an arbitrary power-of-two word width.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage : serial_to_parallel32_pkg

// File: rtl/serial_to_parallel32_if.sv
// Serial input stream, parallel output stream and fill level of the deserializer.
interface serial_to_parallel32_if
  import serial_to_parallel32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  localparam int CW = cnt_width(WIDTH);

  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    bit_count;

  // Producer of bits / consumer of words.
  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_data, bit_count
  );

  // The deserializer itself.
  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_data, bit_count
  );

endinterface : serial_to_parallel32_if

// File: rtl/deser_bit_counter.sv
// Modulo-WIDTH bit counter with increment, synchronous clear/reset and a terminal flag.
module deser_bit_counter
  import serial_to_parallel32_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        inc,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        terminal
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      // WIDTH is a power of two, so the natural overflow is the modulo wrap.
      count_q <= count_q + 1'b1;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == LAST);

endmodule : deser_bit_counter

// File: rtl/serial_to_parallel32.sv
// Serial-in, parallel-out deserializer; one finished word may wait on the output
// while the next one shifts in, and only the last bit of a word is back-pressured.
module serial_to_parallel32
  import serial_to_parallel32_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  serial_to_parallel32_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [CW-1:0]    count;
  logic             terminal;
  logic             accept;
  logic             out_take;

  // The completing bit may only enter when the output slot is free or being
  // drained this same cycle, hence the combinational path from out_ready.
  assign bus.in_ready = ~(terminal & out_valid_q & ~bus.out_ready) & ~clear;
  assign accept       = bus.in_valid & bus.in_ready;
  assign out_take     = out_valid_q & bus.out_ready;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign next_word = {shift_q[WIDTH-2:0], bus.in_bit};
    end else begin : g_lsb_first
      assign next_word = {bus.in_bit, shift_q[WIDTH-1:1]};
    end
  endgenerate

  deser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk      (clk),
    .rst_n    (reset_n),
    .clr      (clear),
    .inc      (accept),
    .count    (count),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      shift_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_take) begin
        out_valid_q <= 1'b0;
      end
      // A word completing in the same cycle as a take overrides the drop.
      if (accept) begin
        if (terminal) begin
          out_data_q  <= next_word;
          out_valid_q <= 1'b1;
          shift_q     <= '0;
        end else begin
          shift_q     <= next_word;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.bit_count = count;

endmodule : serial_to_parallel32

// File: tb/tb_serial_to_parallel32.sv
// Directed bench for serial_to_parallel32: MSB-first and LSB-first instances side by side.
module tb_serial_to_parallel32;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic clear   = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  serial_to_parallel32_if #(.WIDTH(32)) if_m ();
  serial_to_parallel32_if #(.WIDTH(32)) if_l ();

  serial_to_parallel32 #(.WIDTH(32), .MSB_FIRST(1'b1)) dut_m (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (if_m.slave)
  );

  serial_to_parallel32 #(.WIDTH(32), .MSB_FIRST(1'b0)) dut_l (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (if_l.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of w MSB-first, starting at w[31], into the MSB-first instance.
  task automatic send_m(input logic [31:0] w, input int n);
    for (int i = 31; i > 31 - n; i--) begin
      if_m.in_valid = 1'b1;
      if_m.in_bit   = w[i];
      step();
    end
    if_m.in_valid = 1'b0;
  endtask

  task automatic send_bit_m(input logic b);
    if_m.in_valid = 1'b1;
    if_m.in_bit   = b;
    step();
    if_m.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    if_m.in_valid = 1'b0; if_m.in_bit = 1'b0; if_m.out_ready = 1'b1;
    if_l.in_valid = 1'b0; if_l.in_bit = 1'b0; if_l.out_ready = 1'b1;
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    total_cnt++;
    if (if_m.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", if_m.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (if_m.out_data !== 32'h0) $display("FAIL reset_out_data got %h exp 00000000", if_m.out_data);
    else pass_cnt++;
    total_cnt++;
    if (if_m.bit_count !== 5'd0) $display("FAIL reset_bit_count got %0d exp 0", if_m.bit_count);
    else pass_cnt++;
    total_cnt++;
    if (if_m.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", if_m.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_word();
    logic [31:0] w = 32'h1234_5678;
    send_m(w, 31);
    total_cnt++;
    if (if_m.bit_count !== 5'd31 || if_m.out_valid !== 1'b0)
      $display("FAIL single_pre_last got cnt=%0d valid=%0b exp cnt=31 valid=0", if_m.bit_count, if_m.out_valid);
    else pass_cnt++;
    send_bit_m(w[0]);
    total_cnt++;
    if (if_m.out_valid !== 1'b1 || if_m.out_data !== 32'h1234_5678)
      $display("FAIL single_word got valid=%0b data=%h exp valid=1 data=12345678", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    total_cnt++;
    if (if_m.bit_count !== 5'd0) $display("FAIL single_wrap got %0d exp 0", if_m.bit_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_m.out_valid !== 1'b0 || if_m.out_data !== 32'h1234_5678)
      $display("FAIL single_drop got valid=%0b data=%h exp valid=0 data=12345678", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] stream = {32'h9876_5432, 32'hFFEE_DDCC};
    logic [31:0] d1 = '0, d2 = '0;
    int pulses = 0, p1 = -1, p2 = -1, ready_drops = 0;
    if_m.out_ready = 1'b1;
    for (int k = 0; k <= 64; k++) begin
      if (k < 64) begin
        if_m.in_valid = 1'b1;
        if_m.in_bit   = stream[63 - k];
      end else begin
        if_m.in_valid = 1'b0;
      end
      if (if_m.in_ready !== 1'b1) ready_drops++;
      step();
      if (if_m.out_valid === 1'b1) begin
        pulses++;
        if (pulses == 1) begin p1 = k; d1 = if_m.out_data; end
        if (pulses == 2) begin p2 = k; d2 = if_m.out_data; end
      end
    end
    if_m.in_valid = 1'b0;
    total_cnt++;
    if (pulses != 2) $display("FAIL b2b_pulses got %0d exp 2", pulses);
    else pass_cnt++;
    total_cnt++;
    if (d1 !== 32'h9876_5432) $display("FAIL b2b_word1 got %h exp 98765432", d1);
    else pass_cnt++;
    total_cnt++;
    if (d2 !== 32'hFFEE_DDCC) $display("FAIL b2b_word2 got %h exp ffeeddcc", d2);
    else pass_cnt++;
    total_cnt++;
    if (p1 != 31 || p2 != 63) $display("FAIL b2b_timing got p1=%0d p2=%0d exp p1=31 p2=63", p1, p2);
    else pass_cnt++;
    total_cnt++;
    if (ready_drops != 0) $display("FAIL b2b_in_ready got %0d drops exp 0", ready_drops);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [31:0] w2 = 32'h7766_5544;
    if_m.out_ready = 1'b0;
    send_m(32'hBBAA_BBAA, 32);
    total_cnt++;
    if (if_m.out_valid !== 1'b1 || if_m.out_data !== 32'hBBAA_BBAA)
      $display("FAIL bp_first got valid=%0b data=%h exp valid=1 data=bbaabbaa", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    send_m(w2, 31);
    if_m.in_valid = 1'b1;
    if_m.in_bit   = w2[0];
    #1;
    total_cnt++;
    if (if_m.in_ready !== 1'b0 || if_m.bit_count !== 5'd31)
      $display("FAIL bp_stall got ready=%0b cnt=%0d exp ready=0 cnt=31", if_m.in_ready, if_m.bit_count);
    else pass_cnt++;
    step();
    total_cnt++;
    if (if_m.out_data !== 32'hBBAA_BBAA || if_m.bit_count !== 5'd31)
      $display("FAIL bp_hold got data=%h cnt=%0d exp data=bbaabbaa cnt=31", if_m.out_data, if_m.bit_count);
    else pass_cnt++;
    if_m.out_ready = 1'b1;
    #1;
    total_cnt++;
    if (if_m.in_ready !== 1'b1) $display("FAIL bp_release_ready got %0b exp 1", if_m.in_ready);
    else pass_cnt++;
    step();
    if_m.in_valid  = 1'b0;
    if_m.out_ready = 1'b0;
    total_cnt++;
    if (if_m.out_valid !== 1'b1 || if_m.out_data !== 32'h7766_5544 || if_m.bit_count !== 5'd0)
      $display("FAIL bp_second got valid=%0b data=%h cnt=%0d exp valid=1 data=77665544 cnt=0",
               if_m.out_valid, if_m.out_data, if_m.bit_count);
    else pass_cnt++;
    if_m.out_ready = 1'b1;
    step();
    total_cnt++;
    if (if_m.out_valid !== 1'b0 || if_m.out_data !== 32'h7766_5544)
      $display("FAIL bp_taken_hold got valid=%0b data=%h exp valid=0 data=77665544", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
  endtask

  task automatic test_clear();
    if_m.out_ready = 1'b1;
    send_m(32'hABCD_EF01, 12);
    total_cnt++;
    if (if_m.bit_count !== 5'd12) $display("FAIL clr_pre_count got %0d exp 12", if_m.bit_count);
    else pass_cnt++;
    clear = 1'b1;
    if_m.in_valid = 1'b1;
    if_m.in_bit   = 1'b1;
    #1;
    total_cnt++;
    if (if_m.in_ready !== 1'b0) $display("FAIL clr_in_ready got %0b exp 0", if_m.in_ready);
    else pass_cnt++;
    step();
    clear = 1'b0;
    if_m.in_valid = 1'b0;
    total_cnt++;
    if (if_m.bit_count !== 5'd0 || if_m.out_valid !== 1'b0 || if_m.out_data !== 32'h7766_5544)
      $display("FAIL clr_state got cnt=%0d valid=%0b data=%h exp cnt=0 valid=0 data=77665544",
               if_m.bit_count, if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    if_m.out_ready = 1'b0;
    send_m(32'h3322_1100, 32);
    total_cnt++;
    if (if_m.out_valid !== 1'b1 || if_m.out_data !== 32'h3322_1100)
      $display("FAIL clr_next_word got valid=%0b data=%h exp valid=1 data=33221100", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    clear = 1'b1;
    step();
    clear = 1'b0;
    total_cnt++;
    if (if_m.out_valid !== 1'b0 || if_m.out_data !== 32'h3322_1100)
      $display("FAIL clr_out_word got valid=%0b data=%h exp valid=0 data=33221100", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_word();
    if_m.out_ready = 1'b0;
    send_m(32'hCAFE_F00D, 32);
    send_m(32'h5A5A_5A5A, 20);
    total_cnt++;
    if (if_m.bit_count !== 5'd20 || if_m.out_valid !== 1'b1)
      $display("FAIL rst_pre got cnt=%0d valid=%0b exp cnt=20 valid=1", if_m.bit_count, if_m.out_valid);
    else pass_cnt++;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    total_cnt++;
    if (if_m.bit_count !== 5'd0 || if_m.out_valid !== 1'b0 || if_m.out_data !== 32'h0)
      $display("FAIL rst_mid got cnt=%0d valid=%0b data=%h exp cnt=0 valid=0 data=00000000",
               if_m.bit_count, if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    if_m.out_ready = 1'b1;
    send_m(32'h1234_5678, 32);
    total_cnt++;
    if (if_m.out_valid !== 1'b1 || if_m.out_data !== 32'h1234_5678)
      $display("FAIL rst_next_word got valid=%0b data=%h exp valid=1 data=12345678", if_m.out_valid, if_m.out_data);
    else pass_cnt++;
    step();
  endtask

  task automatic test_lsb_first();
    logic [31:0] w = 32'hA500_0001;
    if_l.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if_l.in_valid = 1'b1;
      if_l.in_bit   = w[i];
      step();
      if (i == 30) begin
        total_cnt++;
        if (if_l.bit_count !== 5'd31 || if_l.out_valid !== 1'b0)
          $display("FAIL lsb_pre_last got cnt=%0d valid=%0b exp cnt=31 valid=0", if_l.bit_count, if_l.out_valid);
        else pass_cnt++;
      end
    end
    if_l.in_valid = 1'b0;
    total_cnt++;
    if (if_l.out_valid !== 1'b1 || if_l.out_data !== 32'hA500_0001)
      $display("FAIL lsb_word got valid=%0b data=%h exp valid=1 data=a5000001", if_l.out_valid, if_l.out_data);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_reset_mid_word();
    test_lsb_first();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_serial_to_parallel32

// File: doc/serial_to_parallel32.md
Name: serial_to_parallel32

Overview:
Serial-in, parallel-out deserializer that feeds a downstream 32-bit holding register. It accepts one bit per cycle on a valid/ready handshake and assembles WIDTH bits into a word. It presents the word on a valid/ready output port. Backpressure stalls only the final bit of a word, so one complete word can wait on the output while the next one is being shifted in.

Parameters:
WIDTH, 32, word width in bits; must be a power of two and at least 2.
MSB_FIRST, 1, 1 means the first accepted bit becomes out_data[WIDTH-1]; 0 means it becomes out_data[0].

Ports:
clk  input  1  single clock; all state updates on the posedge.
reset_n  input  1  synchronous active-low reset, sampled on the clk posedge.
clear  input  1  synchronous flush of the partial word and the output word; lower priority than reset_n.
in_valid  input  1  in_bit is valid this cycle.
in_bit  input  1  serial data bit.
in_ready  output  1  deserializer can take in_bit this cycle (combinational).
out_valid  output  1  out_data holds a complete word.
out_ready  input  1  consumer takes out_data this cycle.
out_data  output  WIDTH  assembled word.
bit_count  output  $clog2(WIDTH)  number of bits held in the partial word.

Behaviour:
- Reset (reset_n=0 at posedge): shift_reg=0, bit_count=0, out_data=0, out_valid=0. This discards any partial word.
- accept = in_valid & in_ready. out_take = out_valid & out_ready.
- in_ready = ~(bit_count==WIDTH-1 & out_valid & ~out_ready) & ~clear.
  - This is combinational from out_ready, by design.
  - It depends on in_valid not at all.
- On accept with bit_count < WIDTH-1:
  - MSB_FIRST=1: shift_reg <= {shift_reg[WIDTH-2:0], in_bit}.
  - MSB_FIRST=0: shift_reg <= {in_bit, shift_reg[WIDTH-1:1]}.
  - bit_count increments by 1.
- On accept with bit_count == WIDTH-1 (word complete):
  - out_data <= assembled word, including the current in_bit, in the same shift direction.
  - out_valid <= 1.
  - shift_reg <= 0 and bit_count <= 0 (wrap-around).
- Latency: out_valid rises on the posedge that samples the WIDTH-th accepted bit. The word is visible in the cycle after that bit is presented.
- out_valid falls on out_take, unless a new word completes in the same cycle. If it does, out_valid stays 1 and out_data updates (back-to-back words, no bubble).
- With no accept and no take, all state holds; in_bit is ignored while in_valid=0.
- out_data holds its last value after it is taken. It is not cleared on take.
- clear=1 (reset_n=1):
  - shift_reg=0, bit_count=0, out_valid=0; out_data holds.
  - No bit is accepted that cycle.
- Priority: reset_n, then clear, then normal operation.

Decomposition:
- Shared header file holds WIDTH default 32 and the counter width localparam CNT_W = $clog2(WIDTH). No other shared types are needed.
- One sub-module: deser_bit_counter. It is a modulo-WIDTH counter with inc, sync clear, sync active-low reset and a terminal flag (count==WIDTH-1).
- The shift register, output register and handshake logic stay in the top module.

Test Plan:
1. Single word: reset, then send 0x12345678 MSB-first with in_valid=1 every cycle and out_ready=1. Required: out_valid=1 and out_data=0x12345678 exactly one cycle after bit 32, bit_count back to 0, and out_valid drops the following cycle.
2. Back-to-back: stream 0x98765432 then 0xFFEEDDCC continuously with out_ready=1. Required: two single-cycle out_valid pulses 32 cycles apart carrying those values, and in_ready never drops.
3. Backpressure: out_ready=0, send 0xBBAABBAA then 31 bits of 0x77665544. Required: in_ready=0 with bit_count=31, out_data stays 0xBBAABBAA. Raise out_ready for one cycle. Required: last bit accepted that cycle, and the next cycle shows out_data=0x77665544 with out_valid=1.
4. Clear mid-word: after 12 bits (bit_count=12), pulse clear with in_valid=1. Required: bit_count=0, out_valid=0, the bit presented in that cycle is dropped, and a following 0x33221100 assembles correctly.
5. Reset mid-word and mid-hold: reset_n=0 for one cycle at bit_count=20 while out_valid=1. Required: all outputs zero the next cycle, and the next 32 bits of 0x12345678 assemble correctly.
6. LSB-first instance (MSB_FIRST=0): send 0xA5000001 LSB-first. Required: out_data=0xA5000001.
